// File: rtl/rf_tree_walker.sv
// rf_tree_walker
//   Pulls one sample (NUM_FEAT signed features, feature 0 first) out of the
//   upstream sample FIFO into a local register file. It then walks one
//   decision tree held in an external synchronous node memory, starting at
//   the root, until it reaches a leaf. The leaf class is offered on a
//   valid/ready port to the voting stage. Only after that handshake does it
//   take the next sample.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   i_root_addr   root node address, captured when a new sample starts
//   o_pop         single-cycle pop request to the FIFO
//   i_front       FIFO head data, qualified by i_vld
//   i_vld         one-cycle strobe answering an o_pop
//   i_empty       FIFO empty flag
//   o_node_rd     node memory read enable
//   o_node_addr   node memory address
//   i_node_data   node word, valid the cycle after o_node_rd. The fields,
//                 from MSB to LSB, are is_leaf, feat_idx, threshold, left
//                 and right. A leaf keeps its class in the low CLASS_W bits.
//   o_class       result class
//   o_class_vld   result valid, held until i_class_rdy
//   i_class_rdy   downstream ready
//   o_err         the walk aborted (depth overflow or bad feature index)
//   o_busy        high whenever the walker is not idle
module rf_tree_walker #(
  parameter int NUM_FEAT    = 8,
  parameter int FEAT_IDX_W  = 3,
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 10,
  parameter int CLASS_W     = 4,
  parameter int MAX_DEPTH   = 16,
  localparam int NODE_W     = 1 + FEAT_IDX_W + DATA_W + 2*ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   i_root_addr,
  output logic                o_pop,
  input  logic [DATA_W-1:0]   i_front,
  input  logic                i_vld,
  input  logic                i_empty,
  output logic                o_node_rd,
  output logic [ADDR_W-1:0]   o_node_addr,
  input  logic [NODE_W-1:0]   i_node_data,
  output logic [CLASS_W-1:0]  o_class,
  output logic                o_class_vld,
  input  logic                i_class_rdy,
  output logic                o_err,
  output logic                o_busy
);

  localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

  typedef enum logic [2:0] {IDLE, POP, WAITD, FETCH, EVAL, OUT} state_t;

  state_t                    state;
  logic [ADDR_W-1:0]         cur_addr;
  logic [FEAT_IDX_W-1:0]     feat_cnt;
  logic [DEPTH_W-1:0]        depth;
  logic signed [DATA_W-1:0]  feat [NUM_FEAT];

  logic                      node_is_leaf;
  logic [FEAT_IDX_W-1:0]     node_feat;
  logic signed [DATA_W-1:0]  node_thr;
  logic [ADDR_W-1:0]         node_left;
  logic [ADDR_W-1:0]         node_right;
  logic [CLASS_W-1:0]        node_class;
  logic signed [DATA_W-1:0]  feat_sel;
  logic                      feat_bad;
  logic                      depth_full;
  logic                      go_left;

  // Split the node word into its fields. The class of a leaf shares its
  // bits with the right-child field of an internal node.
  assign node_is_leaf = i_node_data[NODE_W-1];
  assign node_feat    = i_node_data[NODE_W-2 -: FEAT_IDX_W];
  assign node_thr     = i_node_data[2*ADDR_W +: DATA_W];
  assign node_left    = i_node_data[ADDR_W +: ADDR_W];
  assign node_right   = i_node_data[0 +: ADDR_W];
  assign node_class   = i_node_data[CLASS_W-1:0];

  // The feature index is widened by one bit so that the range check still
  // works when NUM_FEAT equals 2**FEAT_IDX_W.
  assign feat_bad   = {1'b0, node_feat} >= (FEAT_IDX_W+1)'(NUM_FEAT);
  assign depth_full = depth == DEPTH_W'(MAX_DEPTH - 1);
  assign feat_sel   = feat[node_feat];
  // Full-width signed compare. A feature equal to the threshold goes left.
  assign go_left    = feat_sel <= node_thr;

  // The node address always follows cur_addr. It only matters while
  // o_node_rd is high.
  assign o_node_addr = cur_addr;

  // Single walker FSM. Every output is a register.
  // o_pop and o_node_rd are single-cycle strobes. They default low and are
  // only raised on the transition that needs them, so at most one pop is
  // ever outstanding: the next pop waits for i_vld.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cur_addr    <= '0;
      feat_cnt    <= '0;
      depth       <= '0;
      o_pop       <= 1'b0;
      o_node_rd   <= 1'b0;
      o_class     <= '0;
      o_class_vld <= 1'b0;
      o_err       <= 1'b0;
      o_busy      <= 1'b0;
      for (int i = 0; i < NUM_FEAT; i++) begin
        feat[i] <= '0;
      end
    end else begin
      o_pop     <= 1'b0;
      o_node_rd <= 1'b0;
      case (state)
        IDLE: begin
          if (!i_empty) begin
            cur_addr <= i_root_addr;
            feat_cnt <= '0;
            depth    <= '0;
            o_busy   <= 1'b1;
            state    <= POP;
          end
        end
        POP: begin
          if (!i_empty) begin
            o_pop <= 1'b1;
            state <= WAITD;
          end
        end
        WAITD: begin
          if (i_vld) begin
            feat[feat_cnt] <= i_front;
            if (feat_cnt == FEAT_IDX_W'(NUM_FEAT - 1)) begin
              o_node_rd <= 1'b1;
              state     <= FETCH;
            end else begin
              feat_cnt <= feat_cnt + 1'b1;
              state    <= POP;
            end
          end
        end
        FETCH: begin
          state <= EVAL;
        end
        EVAL: begin
          if (node_is_leaf) begin
            o_class     <= node_class;
            o_err       <= 1'b0;
            o_class_vld <= 1'b1;
            state       <= OUT;
          end else if (feat_bad || depth_full) begin
            o_class     <= '0;
            o_err       <= 1'b1;
            o_class_vld <= 1'b1;
            state       <= OUT;
          end else begin
            depth     <= depth + 1'b1;
            cur_addr  <= go_left ? node_left : node_right;
            o_node_rd <= 1'b1;
            state     <= FETCH;
          end
        end
        OUT: begin
          if (i_class_rdy) begin
            o_class_vld <= 1'b0;
            o_busy      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/rf_tree_walker.md
Name: rf_tree_walker

Overview:
- Downstream consumer of sample_fifo. Pops one sample (NUM_FEAT signed 16-bit features, feature 0 first) into a local feature register file.
- Walks one decision tree stored in an external synchronous node memory, root first, until it reaches a leaf.
- Presents the leaf class on a valid/ready output to the voting stage, then takes the next sample.

Parameters:
- NUM_FEAT, 8, features per sample; must be >= 2.
- FEAT_IDX_W, 3, feature index width; 2**FEAT_IDX_W >= NUM_FEAT.
- DATA_W, 16, feature and threshold width, signed two's complement.
- ADDR_W, 10, node memory address width.
- CLASS_W, 4, class label width.
- MAX_DEPTH, 16, maximum internal nodes visited before aborting.
- NODE_W, 1+FEAT_IDX_W+DATA_W+2*ADDR_W (40 by default), node word width. Derived; never overridden.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_root_addr  in  ADDR_W  root node address; sampled when leaving IDLE
- o_pop  out  1  pop request to the FIFO; single-cycle pulse
- i_front  in  DATA_W  FIFO head data
- i_vld  in  1  qualifies i_front for one cycle
- i_empty  in  1  FIFO empty
- o_node_rd  out  1  node memory read enable
- o_node_addr  out  ADDR_W  node memory address
- i_node_data  in  NODE_W  node word; valid exactly 1 cycle after o_node_rd
  - Field layout, MSB to LSB: is_leaf, feat_idx, threshold, left, right.
  - For a leaf, the class is i_node_data[CLASS_W-1:0].
- o_class  out  CLASS_W  result class
- o_class_vld  out  1  result valid
- i_class_rdy  in  1  downstream ready
- o_err  out  1  depth overflow or bad feat_idx; qualified by o_class_vld
- o_busy  out  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, rst_n=0): all outputs 0; state IDLE; counters 0; feature registers 0.
- Clock and reset: one clock. Reset is asynchronous and active-low; the clock port is clk and the reset port is rst_n.
- States: IDLE, POP, WAITD, FETCH, EVAL, OUT.
- IDLE:
  - If !i_empty: latch i_root_addr into cur_addr, clear feat_cnt and depth, go to POP.
- POP:
  - If !i_empty: o_pop=1 for exactly this cycle, go to WAITD.
  - Else stay in POP with o_pop=0.
- WAITD:
  - Wait with o_pop=0 until i_vld; any latency is tolerated.
  - On i_vld: feat[feat_cnt] <= i_front.
  - If feat_cnt==NUM_FEAT-1, go to FETCH; else feat_cnt++ and go to POP.
  - At most one pop is outstanding at any time.
  - i_vld seen outside WAITD is ignored.
- FETCH:
  - o_node_rd=1 and o_node_addr=cur_addr for one cycle, then go to EVAL.
- EVAL (consumes i_node_data):
  - If is_leaf: o_class <= data[CLASS_W-1:0], o_err <= 0, go to OUT.
  - Else if feat_idx >= NUM_FEAT, or depth==MAX_DEPTH-1: o_class <= 0, o_err <= 1, go to OUT.
  - Else: depth++. cur_addr <= left if signed(feat[feat_idx]) <= signed(threshold), otherwise right. Go to FETCH.
- Latency:
  - 2 cycles per node visited (FETCH + EVAL).
  - A depth-d leaf (root = depth 0) is reached with o_class_vld rising 2*(d+1) cycles after the last i_vld.
- OUT:
  - o_class_vld=1; o_class and o_err stay stable while i_class_rdy=0.
  - On i_class_rdy: o_class_vld <= 0, go to IDLE. The next sample starts no earlier than the following cycle.
- Arithmetic rules:
  - The comparison is full-width signed; equality goes left.
  - Child addresses are used verbatim; there is no wrap or range check.
- Reset mid-operation returns to IDLE immediately. A partially popped sample is lost; the FIFO owner must flush.
- Back-to-back samples: no pop is issued until OUT has handshaken.

Test Plan:
- Reset mid-walk:
  - Stimulus: assert rst_n=0 during EVAL.
  - Required: o_class_vld=0, o_pop=0, o_busy=0 immediately (asynchronous); IDLE after release.
- Load and depth-0 leaf:
  - Stimulus: FIFO holds 10..17, 1-cycle pop latency; node 0 is a leaf with class 5.
  - Required: exactly 8 o_pop pulses, never two without an intervening i_vld. o_class=5, o_err=0, o_class_vld 2 cycles after the 8th i_vld.
- Depth-2 path with equality:
  - Stimulus: node0 = {feat 2, thr 12, L=1, R=2}; node1 = {feat 7, thr 16, L=3, R=4}; node3 = leaf class 9; node4 = leaf class 1.
  - Required: feat2=12 goes left (equality). feat7=17>16 goes right to node 4. o_class=1; o_node_addr sequence 0,1,4.
- Signed compare:
  - Stimulus: feature 0 = 16'hFFF0 (-16), thr=5, L to leaf 3, R to leaf 7.
  - Required: class 3.
- Error and backpressure:
  - Stimulus: a self-loop internal node (L=R=0).
  - Required: o_err=1, o_class=0 after MAX_DEPTH node reads.
  - Stimulus: hold i_class_rdy=0 for 5 cycles.
  - Required: outputs stable for those cycles; no o_pop until 1 cycle after the handshake.
- Empty stall:
  - Stimulus: i_empty=1 after 3 features, then deasserted 4 cycles later.
  - Required: o_pop stays 0 while empty and resumes; the walk result is unchanged.
